// File: rtl/riscv_pkg.sv
// Shared types and encodings for the RISC-V pipeline sequencing controller.
package riscv_pkg;

  localparam int RIDX_W = 5;

  localparam logic [6:0] OPC_R    = 7'b0110011;
  localparam logic [6:0] OPC_I    = 7'b0010011;
  localparam logic [6:0] OPC_S    = 7'b0100011;
  localparam logic [6:0] OPC_B    = 7'b1100011;
  localparam logic [6:0] OPC_U    = 7'b0110111;
  localparam logic [6:0] OPC_J    = 7'b1101111;
  localparam logic [6:0] OPC_LOAD = 7'b0000011;

  localparam logic [1:0] FWD_GPR = 2'd0;
  localparam logic [1:0] FWD_EXM = 2'd1;
  localparam logic [1:0] FWD_MWB = 2'd2;

  typedef enum logic [1:0] {ST_RUN, ST_STALL, ST_FLUSH} ctrl_state_e;

  typedef struct packed {
    logic              v;
    logic [RIDX_W-1:0] rd;
    logic              ld;
  } trk_entry_t;

  localparam trk_entry_t TRK_BUBBLE = '0;

endpackage

// File: rtl/riscv_hazard_unit.sv
// Compares decode source registers against the EX/MEM tracker entries:
// load-use hazard detect and forwarding select generation.
module riscv_hazard_unit
  import riscv_pkg::*;
#(
  parameter int REG_W = RIDX_W
) (
  input  logic             dec_valid,
  input  logic [REG_W-1:0] dec_rs1,
  input  logic [REG_W-1:0] dec_rs2,
  input  logic             dec_use_rs1,
  input  logic             dec_use_rs2,
  input  trk_entry_t       ex_ent,
  input  trk_entry_t       mem_ent,
  output logic             hazard,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b
);

  // Entries only carry v=1 for rd!=0, so x0 never matches.
  function automatic logic [1:0] fwd_sel(input logic use_rs, input logic [REG_W-1:0] rs,
                                         input trk_entry_t ex_e, input trk_entry_t mem_e);
    logic [1:0] sel;
    sel = FWD_GPR;
    if (use_rs) begin
      if (ex_e.v && !ex_e.ld && rs == ex_e.rd)
        sel = FWD_EXM;
      else if (mem_e.v && rs == mem_e.rd)
        sel = FWD_MWB;
    end
    return sel;
  endfunction

  logic rs1_ld_hit, rs2_ld_hit;

  always_comb begin
    rs1_ld_hit = dec_use_rs1 && ex_ent.v && ex_ent.ld && dec_rs1 == ex_ent.rd;
    rs2_ld_hit = dec_use_rs2 && ex_ent.v && ex_ent.ld && dec_rs2 == ex_ent.rd;
    hazard     = dec_valid && (rs1_ld_hit || rs2_ld_hit);
    fwd_a      = fwd_sel(dec_use_rs1, dec_rs1, ex_ent, mem_ent);
    fwd_b      = fwd_sel(dec_use_rs2, dec_rs2, ex_ent, mem_ent);
  end

endmodule

// File: rtl/riscv_pipeline_ctrl.sv
// 5-stage pipeline sequencer: stall/flush FSM, destination tracker shift,
// registered forwarding selects and writeback enable.
module riscv_pipeline_ctrl
  import riscv_pkg::*;
#(
  parameter int REG_W        = RIDX_W,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dec_valid,
  input  logic [REG_W-1:0] dec_rs1,
  input  logic [REG_W-1:0] dec_rs2,
  input  logic             dec_use_rs1,
  input  logic             dec_use_rs2,
  input  logic [REG_W-1:0] dec_rd,
  input  logic             dec_wr_rd,
  input  logic             dec_is_load,
  input  logic             ex_redirect,
  output logic             fetch_en,
  output logic             decode_en,
  output logic             flush,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             wb_en,
  output logic [REG_W-1:0] wb_rd
);

  localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  ctrl_state_e      state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  trk_entry_t       ex_ent, mem_ent, wb_ent, dec_ent;
  logic             hazard, issue;
  logic [1:0]       hz_fwd_a, hz_fwd_b;

  riscv_hazard_unit #(.REG_W(REG_W)) u_hazard (
    .dec_valid   (dec_valid),
    .dec_rs1     (dec_rs1),
    .dec_rs2     (dec_rs2),
    .dec_use_rs1 (dec_use_rs1),
    .dec_use_rs2 (dec_use_rs2),
    .ex_ent      (ex_ent),
    .mem_ent     (mem_ent),
    .hazard      (hazard),
    .fwd_a       (hz_fwd_a),
    .fwd_b       (hz_fwd_b)
  );

  // The redirect cycle itself also suppresses issue: decode then holds a
  // wrong-path instruction. flush marks the FLUSH_CYCLES cycles that follow.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    fetch_en  = 1'b1;
    decode_en = 1'b1;
    flush     = 1'b0;
    case (state)
      ST_RUN: begin
        if (ex_redirect) begin
          decode_en = 1'b0;
          state_n   = ST_FLUSH;
          cnt_n     = CNT_LOAD;
        end else if (hazard) begin
          fetch_en  = 1'b0;
          decode_en = 1'b0;
          state_n   = ST_STALL;
        end
      end
      ST_STALL: begin
        if (ex_redirect) begin
          decode_en = 1'b0;
          state_n   = ST_FLUSH;
          cnt_n     = CNT_LOAD;
        end else begin
          state_n = ST_RUN;
        end
      end
      ST_FLUSH: begin
        decode_en = 1'b0;
        flush     = 1'b1;
        if (ex_redirect)
          cnt_n = CNT_LOAD;
        else if (cnt == CNT_LAST)
          state_n = ST_RUN;
        else
          cnt_n = cnt - CNT_LAST;
      end
      default: state_n = ST_RUN;
    endcase
  end

  always_comb begin
    issue      = dec_valid && decode_en && !flush;
    dec_ent.v  = dec_wr_rd && (dec_rd != '0);
    dec_ent.rd = dec_ent.v ? dec_rd : '0;
    dec_ent.ld = dec_ent.v && dec_is_load;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_RUN;
      cnt       <= '0;
      ex_ent    <= TRK_BUBBLE;
      mem_ent   <= TRK_BUBBLE;
      wb_ent    <= TRK_BUBBLE;
      fwd_a_sel <= FWD_GPR;
      fwd_b_sel <= FWD_GPR;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      ex_ent    <= issue ? dec_ent : TRK_BUBBLE;
      mem_ent   <= ex_ent;
      wb_ent    <= mem_ent;
      fwd_a_sel <= issue ? hz_fwd_a : FWD_GPR;
      fwd_b_sel <= issue ? hz_fwd_b : FWD_GPR;
    end
  end

  assign wb_en = wb_ent.v;
  assign wb_rd = wb_ent.rd;

endmodule

// File: tb/tb_riscv_pipeline_ctrl.sv
// Directed scoreboard bench for riscv_pipeline_ctrl (FLUSH_CYCLES=2).
module tb_riscv_pipeline_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       dec_valid, dec_use_rs1, dec_use_rs2, dec_wr_rd, dec_is_load, ex_redirect;
  logic [4:0] dec_rs1, dec_rs2, dec_rd;
  logic       fetch_en, decode_en, flush, wb_en;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic [4:0] wb_rd;

  always #5 clk = ~clk;

  riscv_pipeline_ctrl #(.REG_W(5), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2),
    .dec_rd(dec_rd), .dec_wr_rd(dec_wr_rd), .dec_is_load(dec_is_load),
    .ex_redirect(ex_redirect),
    .fetch_en(fetch_en), .decode_en(decode_en), .flush(flush),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .wb_en(wb_en), .wb_rd(wb_rd)
  );

  typedef struct packed {
    logic dv; logic [4:0] rs1; logic [4:0] rs2; logic u1; logic u2;
    logic [4:0] rd; logic wr; logic ld;
  } dec_t;

  typedef struct {
    string       name;
    logic [11:0] exp;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic dec_t rins(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return '{1'b1, rs1, rs2, 1'b1, 1'b1, rd, 1'b1, 1'b0};
  endfunction

  function automatic dec_t lw(input logic [4:0] rd, input logic [4:0] rs1);
    return '{1'b1, rs1, 5'd0, 1'b1, 1'b0, rd, 1'b1, 1'b1};
  endfunction

  localparam dec_t IDLE = '0;
  localparam dec_t NOP  = '{1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0};

  // Drive one cycle of inputs and queue the outputs expected in that cycle.
  task automatic tick(input string nm, input dec_t d, input logic r, input logic rdr,
                      input logic fe, input logic de, input logic fl,
                      input logic [1:0] fa, input logic [1:0] fb,
                      input logic wbe, input logic [4:0] wrd);
    exp_t e;
    @(posedge clk); #1;
    rst         = r;
    dec_valid   = d.dv;  dec_rs1 = d.rs1; dec_rs2 = d.rs2;
    dec_use_rs1 = d.u1;  dec_use_rs2 = d.u2;
    dec_rd      = d.rd;  dec_wr_rd = d.wr; dec_is_load = d.ld;
    ex_redirect = rdr;
    e.name = nm;
    e.exp  = {fe, de, fl, fa, fb, wbe, wrd};
    q.push_back(e);
  endtask

  // Monitor: every cycle with a pending expectation is compared mid-cycle.
  exp_t        mon_e;
  logic [11:0] mon_got;
  initial begin
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        mon_e   = q.pop_front();
        mon_got = {fetch_en, decode_en, flush, fwd_a_sel, fwd_b_sel, wb_en, wb_rd};
        checks++;
        if (mon_got !== mon_e.exp) begin
          errors++;
          $display("FAIL %s: got fe,de,fl,fa,fb,wbe,wbrd=%b required %b",
                   mon_e.name, mon_got, mon_e.exp);
        end
      end
    end
  end

  initial begin
    rst = 1'b0;
    {dec_valid, dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2, dec_rd, dec_wr_rd, dec_is_load} = '0;
    ex_redirect = 1'b0;
    repeat (2) @(posedge clk);
    //    name                 instr           rst rdr  fe de fl fa fb wbe wbrd
    tick("reset state",        IDLE,           1, 0,    1, 1, 0, 0, 0, 0, 0);
    tick("t1 add x1",          rins(1, 2, 3),  1, 0,    1, 1, 0, 0, 0, 0, 0);
    tick("t1 add x4,x1",       rins(4, 1, 5),  1, 0,    1, 1, 0, 0, 0, 0, 0);
    tick("t1 fwd_a=1",         IDLE,           1, 0,    1, 1, 0, 1, 0, 0, 0);
    tick("t1 wb x1",           IDLE,           1, 0,    1, 1, 0, 0, 0, 1, 1);
    tick("t1 wb x4",           IDLE,           1, 0,    1, 1, 0, 0, 0, 1, 4);
    tick("t2 add x1",          rins(1, 2, 3),  1, 0,    1, 1, 0, 0, 0, 0, 0);
    tick("t2 nop",             NOP,            1, 0,    1, 1, 0, 0, 0, 0, 0);
    tick("t2 sub x6,x7,x1",    rins(6, 7, 1),  1, 0,    1, 1, 0, 0, 0, 0, 0);
    tick("t2 fwd_b=2 wb x1",   IDLE,           1, 0,    1, 1, 0, 0, 2, 1, 1);
    tick("t2 nop no wb",       IDLE,           1, 0,    1, 1, 0, 0, 0, 0, 0);
    tick("t2 wb x6",           IDLE,           1, 0,    1, 1, 0, 0, 0, 1, 6);
    tick("t3 lw x8",           lw(8, 1),       1, 0,    1, 1, 0, 0, 0, 0, 0);
    tick("t3 load-use stall",  rins(9, 8, 8),  1, 0,    0, 0, 0, 0, 0, 0, 0);
    tick("t3 reissue",         rins(9, 8, 8),  1, 0,    1, 1, 0, 0, 0, 0, 0);
    tick("t3 fwd 2/2 wb x8",   IDLE,           1, 0,    1, 1, 0, 2, 2, 1, 8);
    tick("t3 gap",             IDLE,           1, 0,    1, 1, 0, 0, 0, 0, 0);
    tick("t3 wb x9",           IDLE,           1, 0,    1, 1, 0, 0, 0, 1, 9);
    tick("t4 redirect",        rins(10, 2, 3), 1, 1,    1, 0, 0, 0, 0, 0, 0);
    tick("t4 flush 1",         rins(11, 2, 3), 1, 0,    1, 0, 1, 0, 0, 0, 0);
    tick("t4 flush 2",         rins(12, 2, 3), 1, 0,    1, 0, 1, 0, 0, 0, 0);
    tick("t4 run x13",         rins(13, 2, 3), 1, 0,    1, 1, 0, 0, 0, 0, 0);
    tick("t4 bubble wb 1",     IDLE,           1, 0,    1, 1, 0, 0, 0, 0, 0);
    tick("t4 bubble wb 2",     IDLE,           1, 0,    1, 1, 0, 0, 0, 0, 0);
    tick("t4 wb x13",          IDLE,           1, 0,    1, 1, 0, 0, 0, 1, 13);
    tick("t5 add x0",          rins(0, 1, 2),  1, 0,    1, 1, 0, 0, 0, 0, 0);
    tick("t5 add x3,x0,x0",    rins(3, 0, 0),  1, 0,    1, 1, 0, 0, 0, 0, 0);
    tick("t5 no fwd x0",       IDLE,           1, 0,    1, 1, 0, 0, 0, 0, 0);
    tick("t5 no wb x0",        IDLE,           1, 0,    1, 1, 0, 0, 0, 0, 0);
    tick("t5 wb x3",           IDLE,           1, 0,    1, 1, 0, 0, 0, 1, 3);
    tick("t6 lw x5",           lw(5, 1),       1, 0,    1, 1, 0, 0, 0, 0, 0);
    tick("t6 stall",           rins(6, 5, 0),  1, 0,    0, 0, 0, 0, 0, 0, 0);
    tick("t6 rst in stall",    rins(6, 5, 0),  0, 0,    1, 1, 0, 0, 0, 0, 0);
    tick("t6 after rst",       IDLE,           1, 0,    1, 1, 0, 0, 0, 0, 0);
    tick("t6 no stale wb",     IDLE,           1, 0,    1, 1, 0, 0, 0, 0, 0);
    tick("t7 redirect",        IDLE,           1, 1,    1, 0, 0, 0, 0, 0, 0);
    tick("t7 rst in flush",    IDLE,           0, 0,    1, 0, 1, 0, 0, 0, 0);
    tick("t7 run after rst",   IDLE,           1, 0,    1, 1, 0, 0, 0, 0, 0);
    tick("t8 redirect",        IDLE,           1, 1,    1, 0, 0, 0, 0, 0, 0);
    tick("t8 flush 1",         IDLE,           1, 0,    1, 0, 1, 0, 0, 0, 0);
    tick("t8 redirect in fl",  IDLE,           1, 1,    1, 0, 1, 0, 0, 0, 0);
    tick("t8 restart 1",       IDLE,           1, 0,    1, 0, 1, 0, 0, 0, 0);
    tick("t8 restart 2",       IDLE,           1, 0,    1, 0, 1, 0, 0, 0, 0);
    tick("t8 run",             IDLE,           1, 0,    1, 1, 0, 0, 0, 0, 0);
    tick("t9 lw x7",           lw(7, 1),       1, 0,    1, 1, 0, 0, 0, 0, 0);
    tick("t9 hazard+redirect", rins(8, 7, 0),  1, 1,    1, 0, 0, 0, 0, 0, 0);
    tick("t9 flush 1",         IDLE,           1, 0,    1, 0, 1, 0, 0, 0, 0);
    tick("t9 flush 2 wb x7",   IDLE,           1, 0,    1, 0, 1, 0, 0, 1, 7);
    tick("t9 run no wb",       IDLE,           1, 0,    1, 1, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d pending, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
